prbs7_gen64: RTL and testbench

- 64-bit-per-cycle PRBS7 word generator (x^7+x^6+1 sequence) for the serial-link test path.
- It is the transmit-side partner of the 64-bit PRBS7 checker and uses the same bit ordering and self-synchronising state rule, so a fed-through stream checks clean.
- Adds user-byte overlay under a 16-bit mask, plus single-shot and periodic bit-error injection, for exercising checker error and user-data counters.

---
 rtl/prbs7_gen64.sv | 180 ++++++++++++++++++
 tb/tb_prbs7_gen64.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prbs7_gen64.sv
// PRBS7 (x^7+x^6+1) word generator, 64 bits per clock, with user-byte overlay and
// optional bit-error injection enabled by defining PRBS7_GEN_ERR_INJECT_EN.
module prbs7_gen64 #(
    parameter logic [6:0] DEFAULT_SEED = 7'h7F,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dis,
    input  logic             reseed,
    input  logic [6:0]       seed,
    input  logic [15:0]      mask,
    input  logic [7:0]       user_data,
    input  logic             inject_err,
    input  logic [5:0]       err_bit_sel,
    input  logic [15:0]      err_period,
    output logic [63:0]      dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] word_count,
    output logic [15:0]      injected_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Bit i of the word is the i-th bit shifted out of the 7-bit LFSR.
    function automatic logic [63:0] prbs_word(input logic [6:0] l);
        logic [6:0]  c;
        logic        p;
        logic [63:0] w;
        c = l;
        w = 64'd0;
        for (int i = 0; i < 64; i++) begin
            p    = c[1] ^ c[0];
            w[i] = p;
            c    = {p, c[6:1]};
        end
        return w;
    endfunction

    function automatic logic [63:0] user_pattern(input logic [15:0] m, input logic [7:0] u);
        logic [63:0] spread;
        spread = 64'd0;
        for (int k = 0; k < 8; k++) begin
            spread[8*k+7] = u[k];
        end
        return {4{m}} & spread;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [63:0]      dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             emit_s;
    logic [63:0]      err_pat_s;
    logic [63:0]      word_s;

    // FSM next-state decode; dis outranks reseed so a simultaneous reseed is dropped.
    always_comb begin
        state_d = state_q;
        emit_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!dis) state_d = S_LOAD;
                else      state_d = S_IDLE;
            end
            S_LOAD: begin
                if (dis)         state_d = S_HOLD;
                else if (reseed) state_d = S_LOAD;
                else             state_d = S_RUN;
            end
            S_RUN: begin
                if (dis) begin
                    state_d = S_HOLD;
                end else if (reseed) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_RUN;
                    emit_s  = 1'b1;
                end
            end
            S_HOLD: begin
                if (dis)         state_d = S_HOLD;
                else if (reseed) state_d = S_LOAD;
                else             state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign word_s = prbs_word(lfsr_q) ^ user_pattern(mask, user_data) ^ err_pat_s;

    // Datapath next-state; the LFSR follows the word actually sent, overlay and errors included.
    always_comb begin
        lfsr_d  = lfsr_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        wcnt_d  = wcnt_q;
        if (state_q == S_LOAD) begin
            lfsr_d = (seed == 7'h00) ? DEFAULT_SEED : seed;
        end else if (emit_s) begin
            lfsr_d  = word_s[63:57];
            dout_d  = word_s;
            valid_d = 1'b1;
            wcnt_d  = wcnt_q + CNT_W'(1);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Main state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= 7'd0;
            dout_q  <= 64'd0;
            valid_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef PRBS7_GEN_ERR_INJECT_EN
    logic        pend_q, pend_d;
    logic [15:0] per_q, per_d;
    logic [15:0] inj_q, inj_d;
    logic [15:0] per_inc_s;
    logic        per_hit_s;
    logic        apply_s;

    // Pending and periodic sources merge into one flip per word.
    always_comb begin
        per_inc_s = (per_q >= err_period) ? 16'd1 : per_q + 16'd1;
        per_hit_s = emit_s && (err_period != 16'd0) && (per_inc_s == err_period);
        apply_s   = emit_s && (pend_q || per_hit_s);
        err_pat_s = apply_s ? (64'd1 << err_bit_sel) : 64'd0;
        pend_d    = pend_q ? !emit_s : inject_err;
        if (err_period == 16'd0) per_d = 16'd0;
        else if (emit_s)         per_d = per_inc_s;
        else                     per_d = per_q;
        if (apply_s && (inj_q != 16'hFFFF)) inj_d = inj_q + 16'd1;
        else                                inj_d = inj_q;
    end

    // Injection registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            per_q  <= 16'd0;
            inj_q  <= 16'd0;
        end else begin
            pend_q <= pend_d;
            per_q  <= per_d;
            inj_q  <= inj_d;
        end
    end

    assign injected_count = inj_q;
`else
    logic unused_inj_s;
    assign unused_inj_s   = ^{inject_err, err_bit_sel, err_period};
    assign err_pat_s      = 64'd0;
    assign injected_count = 16'd0;
`endif

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_prbs7_gen64.sv
// Directed self-checking bench for prbs7_gen64; expected words come from an
// independent PRBS7 recurrence s[n+7] = s[n] ^ s[n+1].
module tb_prbs7_gen64;

    logic        clk = 1'b0;
    logic        reset, dis, reseed, inject_err;
    logic [6:0]  seed;
    logic [15:0] mask, err_period;
    logic [7:0]  user_data;
    logic [5:0]  err_bit_sel;
    logic [63:0] dout;
    logic        dout_valid;
    logic [31:0] word_count;
    logic [15:0] injected_count;

    int          errors = 0;
    int          checks = 0;
    logic [6:0]  st;
    logic [63:0] exp_w;
    logic [63:0] hold_w;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    prbs7_gen64 dut (
        .clk(clk), .reset(reset), .dis(dis), .reseed(reseed), .seed(seed),
        .mask(mask), .user_data(user_data), .inject_err(inject_err),
        .err_bit_sel(err_bit_sel), .err_period(err_period),
        .dout(dout), .dout_valid(dout_valid), .word_count(word_count),
        .injected_count(injected_count)
    );

    function automatic logic [63:0] model_p(input logic [6:0] l);
        logic [70:0] s;
        s      = 71'd0;
        s[6:0] = l;
        for (int n = 0; n < 64; n++) s[n+7] = s[n] ^ s[n+1];
        return s[70:7];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one clock expecting an emitted word equal to the model XOR ov.
    task automatic expect_word(input string tag, input logic [63:0] ov);
        exp_w = model_p(st) ^ ov;
        st    = exp_w[63:57];
        exp_cnt++;
        tick();
        chk({tag, "_valid"}, {63'd0, dout_valid}, 64'd1);
        chk({tag, "_dout"}, dout, exp_w);
    endtask

    initial begin
        reset = 1'b1; dis = 1'b0; reseed = 1'b0; seed = 7'h7F;
        mask = 16'h0000; user_data = 8'h00; inject_err = 1'b0;
        err_bit_sel = 6'd0; err_period = 16'd0; exp_cnt = 32'd0;
        tick();
        tick();
        chk("rst_dout", dout, 64'd0);
        chk("rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_wcnt", {32'd0, word_count}, 64'd0);
        chk("rst_icnt", {48'd0, injected_count}, 64'd0);

        reset = 1'b0;
        tick();
        chk("lat_edge1", {63'd0, dout_valid}, 64'd0);
        tick();
        chk("lat_edge2", {63'd0, dout_valid}, 64'd0);
        st = 7'h7F;
        expect_word("first", 64'd0);
        chk("first_low16", {48'd0, dout[15:0]}, 64'h3040);
        for (int i = 0; i < 20; i++) expect_word("chain", 64'd0);
        chk("wcnt_chain", {32'd0, word_count}, {32'd0, exp_cnt});

        hold_w = exp_w;
        dis = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {63'd0, dout_valid}, 64'd0);
            chk("hold_dout", dout, hold_w);
        end
        dis = 1'b0;
        tick();
        chk("resume_gap", {63'd0, dout_valid}, 64'd0);
        for (int i = 0; i < 3; i++) expect_word("resume", 64'd0);
        chk("wcnt_hold", {32'd0, word_count}, {32'd0, exp_cnt});

        mask = 16'h8080; user_data = 8'hA5;
        expect_word("ovl_a5", 64'h8000_8000_0080_0080);
        mask = 16'h7F7F; user_data = 8'hFF;
        expect_word("ovl_nonlane", 64'd0);
        mask = 16'hFFFF; user_data = 8'hFF;
        expect_word("ovl_all", 64'h8080_8080_8080_8080);
        mask = 16'h0000; user_data = 8'h00;
        for (int i = 0; i < 3; i++) expect_word("ovl_off", 64'd0);

`ifdef PRBS7_GEN_ERR_INJECT_EN
        err_bit_sel = 6'd10;
        inject_err  = 1'b1;
        expect_word("inj_same", 64'd0);
        inject_err = 1'b0;
        expect_word("inj_flip", 64'd1 << 10);
        expect_word("inj_after", 64'd0);
        chk("inj_cnt1", {48'd0, injected_count}, 64'd1);
        err_period = 16'd4;
        for (int i = 0; i < 8; i++) expect_word("per4", ((i % 4) == 3) ? (64'd1 << 10) : 64'd0);
        chk("inj_cnt3", {48'd0, injected_count}, 64'd3);
        expect_word("coin_w0", 64'd0);
        expect_word("coin_w1", 64'd0);
        inject_err = 1'b1;
        expect_word("coin_w2", 64'd0);
        inject_err = 1'b0;
        expect_word("coin_w3", 64'd1 << 10);
        chk("inj_cnt4", {48'd0, injected_count}, 64'd4);
        err_period = 16'd0;
        for (int i = 0; i < 5; i++) expect_word("per_off", 64'd0);
        chk("inj_cnt_end", {48'd0, injected_count}, 64'd4);
`else
        err_bit_sel = 6'd10;
        err_period  = 16'd4;
        inject_err  = 1'b1;
        expect_word("noinj_pulse", 64'd0);
        inject_err = 1'b0;
        for (int i = 0; i < 6; i++) expect_word("noinj", 64'd0);
        chk("noinj_cnt", {48'd0, injected_count}, 64'd0);
        err_period = 16'd0;
`endif

        seed   = 7'h00;
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        chk("reseed_gap1", {63'd0, dout_valid}, 64'd0);
        tick();
        chk("reseed_gap2", {63'd0, dout_valid}, 64'd0);
        st = 7'h7F;
        expect_word("seed0_first", 64'd0);
        chk("seed0_low16", {48'd0, dout[15:0]}, 64'h3040);
        for (int i = 0; i < 300; i++) expect_word("long", 64'd0);
        chk("wcnt_long", {32'd0, word_count}, {32'd0, exp_cnt});

        reset = 1'b1;
        tick();
        chk("mid_rst_dout", dout, 64'd0);
        chk("mid_rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("mid_rst_wcnt", {32'd0, word_count}, 64'd0);
        chk("mid_rst_icnt", {48'd0, injected_count}, 64'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_gap", {63'd0, dout_valid}, 64'd0);
        st      = 7'h7F;
        exp_cnt = 32'd0;
        expect_word("post_rst_first", 64'd0);
        chk("post_rst_wcnt", {32'd0, word_count}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
